// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: FSM state encoding, default
// parameter values, buffer geometry and small pattern helpers.
package jogador_automatico_pkg;

    localparam int unsigned PROF_PADRAO     = 16;
    localparam int unsigned T_PRESS_PADRAO  = 4;
    localparam int unsigned T_SOLTA_PADRAO  = 4;
    localparam int unsigned T_QUIETO_PADRAO = 16;

    localparam int unsigned LED_W  = 7;
    localparam int unsigned ADDR_W = 4;

    // The same encoding is presented on db_estado.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OBSERVA   = 2'd1,
        PRESSIONA = 2'd2,
        SOLTA     = 2'd3
    } estado_t;

    function automatic logic eh_one_hot(input logic [LED_W-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [1:0] codigo_estado(input estado_t e);
        return e;
    endfunction

endpackage

// File: rtl/jogador_automatico_memoria.sv
// memoria_sequencia: PROF x LED_W register file holding the captured sequence.
// Ports:
//   clock    - write clock
//   we       - write enable
//   endereco - shared read/write address
//   dado_in  - pattern to store
//   dado_out - pattern at endereco (combinational read)
module memoria_sequencia
    import jogador_automatico_pkg::*;
#(
    parameter int unsigned PROF = PROF_PADRAO
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [LED_W-1:0]  dado_in,
    output logic [LED_W-1:0]  dado_out
);

    logic [LED_W-1:0] mem_q [PROF];
    logic             endereco_valido;

    assign endereco_valido = 32'(endereco) < PROF;

    // Contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (we && endereco_valido) begin
            mem_q[endereco] <= dado_in;
        end
    end

    assign dado_out = endereco_valido ? mem_q[endereco] : '0;

endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: watches the game's one-hot LED sequence, records it and,
// after a quiet period, replays it on the button outputs.
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   habilita        - player enable; low returns to IDLE
//   leds            - LED pattern from the game
//   botoes          - registered button pattern to the game
//   jogando         - high during replay (PRESSIONA/SOLTA)
//   overflow        - sticky, pattern arrived with buffer full
//   padrao_invalido - sticky, non-one-hot pattern seen
//   db_contagem     - stored entries minus one (0 when empty)
//   db_estado       - current FSM state code
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int unsigned PROF     = PROF_PADRAO,
    parameter int unsigned T_PRESS  = T_PRESS_PADRAO,
    parameter int unsigned T_SOLTA  = T_SOLTA_PADRAO,
    parameter int unsigned T_QUIETO = T_QUIETO_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    input  logic [LED_W-1:0]  leds,
    output logic [LED_W-1:0]  botoes,
    output logic              jogando,
    output logic              overflow,
    output logic              padrao_invalido,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [1:0]        db_estado
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned QW    = (T_QUIETO > 1) ? $clog2(T_QUIETO) : 1;
    localparam int unsigned T_MAX = (T_PRESS > T_SOLTA) ? T_PRESS : T_SOLTA;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    estado_t          estado_q;
    logic [LED_W-1:0] botoes_q;
    logic [LED_W-1:0] leds_ant_q;
    logic [CNT_W-1:0] contagem_q;
    logic [CNT_W-1:0] indice_q;
    logic [QW-1:0]    quieto_q;
    logic [TW-1:0]    timer_q;
    logic             overflow_q;
    logic             invalido_q;

    logic              borda;
    logic              cheio;
    logic              captura;
    logic              fim_quieto;
    logic              we;
    logic [ADDR_W-1:0] endereco;
    logic [LED_W-1:0]  dado_lido;
    logic [CNT_W-1:0]  contagem_m1;

    always_comb begin
        borda      = (estado_q == OBSERVA) && (leds_ant_q == '0) && (leds != '0);
        cheio      = contagem_q >= CNT_W'(PROF);
        captura    = borda && eh_one_hot(leds) && !cheio;
        fim_quieto = (estado_q == OBSERVA) && (leds == '0) &&
                     (quieto_q == QW'(T_QUIETO - 1));
        we         = captura && habilita && !reset;
        // Writes use the fill pointer; otherwise the address is the next entry
        // to replay, so dado_lido is ready on the edge that loads botoes.
        endereco   = captura ? contagem_q[ADDR_W-1:0] : indice_q[ADDR_W-1:0];
        contagem_m1 = contagem_q - CNT_W'(1);
    end

    memoria_sequencia #(
        .PROF(PROF)
    ) u_memoria (
        .clock    (clock),
        .we       (we),
        .endereco (endereco),
        .dado_in  (leds),
        .dado_out (dado_lido)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= IDLE;
            botoes_q   <= '0;
            leds_ant_q <= '0;
            contagem_q <= '0;
            indice_q   <= '0;
            quieto_q   <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            invalido_q <= 1'b0;
        end else if (!habilita) begin
            estado_q <= IDLE;
            botoes_q <= '0;
            quieto_q <= '0;
            timer_q  <= '0;
        end else begin
            case (estado_q)
                IDLE: begin
                    estado_q   <= OBSERVA;
                    contagem_q <= '0;
                    indice_q   <= '0;
                    quieto_q   <= '0;
                    leds_ant_q <= '0;
                    timer_q    <= '0;
                    botoes_q   <= '0;
                end

                OBSERVA: begin
                    leds_ant_q <= leds;
                    if (borda) begin
                        if (!eh_one_hot(leds)) begin
                            invalido_q <= 1'b1;
                        end else if (cheio) begin
                            overflow_q <= 1'b1;
                        end else begin
                            contagem_q <= contagem_q + CNT_W'(1);
                        end
                    end

                    if (leds != '0) begin
                        quieto_q <= '0;
                    end else if (fim_quieto) begin
                        quieto_q <= '0;
                        if (contagem_q != '0) begin
                            estado_q <= PRESSIONA;
                            botoes_q <= dado_lido;
                            indice_q <= indice_q + CNT_W'(1);
                            timer_q  <= '0;
                        end
                    end else begin
                        quieto_q <= quieto_q + QW'(1);
                    end
                end

                PRESSIONA: begin
                    if (timer_q == TW'(T_PRESS - 1)) begin
                        estado_q <= SOLTA;
                        botoes_q <= '0;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                SOLTA: begin
                    if (timer_q == TW'(T_SOLTA - 1)) begin
                        timer_q <= '0;
                        if (indice_q < contagem_q) begin
                            estado_q <= PRESSIONA;
                            botoes_q <= dado_lido;
                            indice_q <= indice_q + CNT_W'(1);
                        end else begin
                            estado_q   <= OBSERVA;
                            contagem_q <= '0;
                            indice_q   <= '0;
                            quieto_q   <= '0;
                            leds_ant_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                default: begin
                    estado_q <= IDLE;
                    botoes_q <= '0;
                end
            endcase
        end
    end

    assign botoes          = botoes_q;
    assign jogando         = (estado_q == PRESSIONA) || (estado_q == SOLTA);
    assign overflow        = overflow_q;
    assign padrao_invalido = invalido_q;
    assign db_contagem     = (contagem_q == '0) ? '0 : contagem_m1[ADDR_W-1:0];
    assign db_estado       = codigo_estado(estado_q);

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

    localparam int unsigned TP   = 4;
    localparam int unsigned TS   = 4;
    localparam int unsigned TQ   = 16;
    localparam int unsigned PROF = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [6:0] leds;
    logic [6:0] botoes;
    logic       jogando;
    logic       overflow;
    logic       padrao_invalido;
    logic [3:0] db_contagem;
    logic [1:0] db_estado;

    always #5 clock = ~clock;

    jogador_automatico #(
        .PROF     (PROF),
        .T_PRESS  (TP),
        .T_SOLTA  (TS),
        .T_QUIETO (TQ)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .leds            (leds),
        .botoes          (botoes),
        .jogando         (jogando),
        .overflow        (overflow),
        .padrao_invalido (padrao_invalido),
        .db_contagem     (db_contagem),
        .db_estado       (db_estado)
    );

    typedef struct packed {
        logic [6:0] b;
        logic [1:0] e;
        logic [3:0] c;
        logic       j;
    } amostra_t;

    int total = 0;
    int bad   = 0;

    amostra_t   obs[$];
    amostra_t   esp[$];
    logic [6:0] esp_ent[$];
    logic       esp_ovf;
    logic       esp_inv;

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic aplicar_reset();
        reset    = 1'b1;
        habilita = 1'b0;
        leds     = 7'h00;
        passo();
        passo();
        reset    = 1'b0;
        habilita = 1'b1;
        passo();
    endtask

    function automatic logic [3:0] dbc(input int n);
        return (n == 0) ? 4'd0 : 4'(n - 1);
    endfunction

    // Reference: captured entries are the one-hot values that appear right
    // after a zero cycle (first PROF only); replay starts on the TQ-th
    // consecutive quiet sample, then each entry is TP cycles on, TS cycles off.
    task automatic modelo(input logic [6:0] lista[$]);
        logic [6:0] ant;
        logic [6:0] v;
        int         quietos;
        int         extra;
        int         i;
        int         n;
        bit         fim;
        esp.delete();
        esp_ent.delete();
        esp_ovf = 1'b0;
        esp_inv = 1'b0;
        ant = 7'h00;
        quietos = 0;
        extra = 0;
        i = 0;
        fim = 0;
        while (!fim && extra < 3 * TQ) begin
            if (i < lista.size()) v = lista[i];
            else begin
                v = 7'h00;
                extra++;
            end
            i++;
            if (ant == 7'h00 && v != 7'h00) begin
                if ($countones(v) != 1) esp_inv = 1'b1;
                else if (esp_ent.size() == PROF) esp_ovf = 1'b1;
                else esp_ent.push_back(v);
            end
            ant = v;
            if (v != 7'h00) quietos = 0;
            else quietos++;
            if (quietos == TQ) begin
                quietos = 0;
                if (esp_ent.size() > 0) fim = 1;
            end
            if (!fim) esp.push_back(amostra_t'{b: 7'h00, e: 2'd1, c: dbc(esp_ent.size()), j: 1'b0});
        end
        if (fim) begin
            n = esp_ent.size();
            foreach (esp_ent[k]) begin
                repeat (TP) esp.push_back(amostra_t'{b: esp_ent[k], e: 2'd2, c: dbc(n), j: 1'b1});
                repeat (TS) esp.push_back(amostra_t'{b: 7'h00, e: 2'd3, c: dbc(n), j: 1'b1});
            end
            esp.push_back(amostra_t'{b: 7'h00, e: 2'd1, c: 4'd0, j: 1'b0});
        end
    endtask

    task automatic executar(input logic [6:0] lista[$], input int ciclos);
        obs.delete();
        for (int t = 0; t < ciclos; t++) begin
            leds = (t < lista.size()) ? lista[t] : 7'h00;
            passo();
            obs.push_back(amostra_t'{b: botoes, e: db_estado, c: db_contagem, j: jogando});
        end
        leds = 7'h00;
    endtask

    function automatic int inicio_replay();
        foreach (esp[t]) if (esp[t].e == 2'd2) return t;
        return -1;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        habilita = 1'b1;
        leds     = 7'h01;
        passo();
        passo();
        total++;
        if ({botoes, jogando, overflow, padrao_invalido, db_contagem, db_estado} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got b=%h j=%b ovf=%b inv=%b c=%0d e=%0d, want all 0",
                     botoes, jogando, overflow, padrao_invalido, db_contagem, db_estado);
        end
        reset = 1'b0;
        leds  = 7'h00;
        passo();
        total++;
        if (db_estado !== 2'd1 || db_contagem !== 4'd0) begin
            bad++;
            $display("FAIL reset_enable: got e=%0d c=%0d, want e=1 c=0", db_estado, db_contagem);
        end
    endtask

    task automatic test_sequencia_basica();
        logic [6:0] lista[$];
        int         runs;
        lista = '{7'h01, 7'h00, 7'h08, 7'h00, 7'h40};
        aplicar_reset();
        modelo(lista);
        executar(lista, esp.size());
        for (int t = 0; t < esp.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL basica_ciclo%0d: got b=%h e=%0d c=%0d j=%b, want b=%h e=%0d c=%0d j=%b",
                         t, obs[t].b, obs[t].e, obs[t].c, obs[t].j, esp[t].b, esp[t].e, esp[t].c, esp[t].j);
                break;
            end
        end
        runs = 0;
        for (int t = 1; t < obs.size(); t++) if (obs[t].b != 0 && obs[t-1].b == 0) runs++;
        total++;
        if (runs !== 3) begin
            bad++;
            $display("FAIL basica_presses: got %0d, want 3", runs);
        end
    endtask

    task automatic test_padrao_segurado();
        logic [6:0] lista[$];
        int         runs;
        lista.delete();
        repeat (10) lista.push_back(7'h04);
        aplicar_reset();
        modelo(lista);
        executar(lista, esp.size());
        for (int t = 0; t < esp.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL segurado_ciclo%0d: got b=%h e=%0d c=%0d j=%b, want b=%h e=%0d c=%0d j=%b",
                         t, obs[t].b, obs[t].e, obs[t].c, obs[t].j, esp[t].b, esp[t].e, esp[t].c, esp[t].j);
                break;
            end
        end
        runs = 0;
        for (int t = 1; t < obs.size(); t++) if (obs[t].b != 0 && obs[t-1].b == 0) runs++;
        total++;
        if (runs !== 1 || db_contagem !== 4'd0) begin
            bad++;
            $display("FAIL segurado_presses: got presses=%0d c=%0d, want presses=1 c=0", runs, db_contagem);
        end
    endtask

    task automatic test_invalido();
        logic [6:0] lista[$];
        lista = '{7'h05, 7'h00, 7'h02};
        aplicar_reset();
        modelo(lista);
        executar(lista, esp.size());
        for (int t = 0; t < esp.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL invalido_ciclo%0d: got b=%h e=%0d c=%0d, want b=%h e=%0d c=%0d",
                         t, obs[t].b, obs[t].e, obs[t].c, esp[t].b, esp[t].e, esp[t].c);
                break;
            end
        end
        total++;
        if (padrao_invalido !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL invalido_flags: got inv=%b ovf=%b, want inv=1 ovf=0", padrao_invalido, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] lista[$];
        int         runs;
        lista.delete();
        for (int i = 0; i < 17; i++) begin
            lista.push_back(7'(1 << (i % 7)));
            lista.push_back(7'h00);
        end
        aplicar_reset();
        modelo(lista);
        executar(lista, esp.size());
        for (int t = 0; t < esp.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL overflow_ciclo%0d: got b=%h e=%0d c=%0d, want b=%h e=%0d c=%0d",
                         t, obs[t].b, obs[t].e, obs[t].c, esp[t].b, esp[t].e, esp[t].c);
                break;
            end
        end
        runs = 0;
        for (int t = 1; t < obs.size(); t++) if (obs[t].b != 0 && obs[t-1].b == 0) runs++;
        total++;
        if (overflow !== 1'b1 || runs !== 16) begin
            bad++;
            $display("FAIL overflow_flag: got ovf=%b presses=%0d, want ovf=1 presses=16", overflow, runs);
        end
    endtask

    task automatic test_habilita();
        logic [6:0] lista[$];
        int         tmo;
        lista = '{7'h03, 7'h00, 7'h01, 7'h00, 7'h02};
        aplicar_reset();
        modelo(lista);
        tmo = inicio_replay();
        executar(lista, tmo + TP + TS + 2);
        for (int t = 0; t < obs.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL habilita_ciclo%0d: got b=%h e=%0d, want b=%h e=%0d",
                         t, obs[t].b, obs[t].e, esp[t].b, esp[t].e);
                break;
            end
        end
        habilita = 1'b0;
        passo();
        total++;
        if (botoes !== 7'h00 || db_estado !== 2'd0 || jogando !== 1'b0 || padrao_invalido !== 1'b1) begin
            bad++;
            $display("FAIL habilita_drop: got b=%h e=%0d j=%b inv=%b, want b=00 e=0 j=0 inv=1",
                     botoes, db_estado, jogando, padrao_invalido);
        end
        habilita = 1'b1;
        passo();
        total++;
        if (db_estado !== 2'd1 || db_contagem !== 4'd0) begin
            bad++;
            $display("FAIL habilita_reenable: got e=%0d c=%0d, want e=1 c=0", db_estado, db_contagem);
        end
    endtask

    task automatic test_reset_meio();
        logic [6:0] lista[$];
        int         tmo;
        lista = '{7'h20, 7'h00, 7'h04, 7'h00, 7'h03};
        aplicar_reset();
        modelo(lista);
        tmo = inicio_replay();
        executar(lista, tmo + 2);
        reset = 1'b1;
        passo();
        total++;
        if ({botoes, jogando, overflow, padrao_invalido, db_contagem, db_estado} !== 15'd0) begin
            bad++;
            $display("FAIL reset_meio: got b=%h j=%b ovf=%b inv=%b c=%0d e=%0d, want all 0",
                     botoes, jogando, overflow, padrao_invalido, db_contagem, db_estado);
        end
        reset = 1'b0;
        passo();
        lista = '{7'h10};
        modelo(lista);
        executar(lista, esp.size());
        for (int t = 0; t < esp.size(); t++) begin
            total++;
            if (obs[t] !== esp[t]) begin
                bad++;
                $display("FAIL reset_fresh_ciclo%0d: got b=%h e=%0d c=%0d, want b=%h e=%0d c=%0d",
                         t, obs[t].b, obs[t].e, obs[t].c, esp[t].b, esp[t].e, esp[t].c);
                break;
            end
        end
    endtask

    task automatic test_aleatorio();
        logic [6:0] lista[$];
        logic [6:0] v;
        int         n;
        for (int it = 0; it < 8; it++) begin
            lista.delete();
            n = $urandom_range(1, 20);
            for (int p = 0; p < n; p++) begin
                v = 7'(1 << $urandom_range(0, 6));
                if ($urandom_range(0, 6) == 0) v = v | 7'(1 << $urandom_range(0, 6));
                repeat ($urandom_range(1, 3)) lista.push_back(v);
                if ($urandom_range(0, 5) != 0) repeat ($urandom_range(1, 4)) lista.push_back(7'h00);
            end
            aplicar_reset();
            modelo(lista);
            executar(lista, esp.size());
            for (int t = 0; t < esp.size(); t++) begin
                total++;
                if (obs[t] !== esp[t]) begin
                    bad++;
                    $display("FAIL aleatorio%0d_ciclo%0d: got b=%h e=%0d c=%0d j=%b, want b=%h e=%0d c=%0d j=%b",
                             it, t, obs[t].b, obs[t].e, obs[t].c, obs[t].j,
                             esp[t].b, esp[t].e, esp[t].c, esp[t].j);
                    break;
                end
            end
            total++;
            if (overflow !== esp_ovf || padrao_invalido !== esp_inv) begin
                bad++;
                $display("FAIL aleatorio%0d_flags: got ovf=%b inv=%b, want ovf=%b inv=%b",
                         it, overflow, padrao_invalido, esp_ovf, esp_inv);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        habilita = 1'b0;
        leds     = 7'h00;
        test_reset();
        test_sequencia_basica();
        test_padrao_segurado();
        test_invalido();
        test_overflow();
        test_habilita();
        test_reset_meio();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter PROF, default 16: sequence buffer depth in entries; address width 4 bits.
REQ-002 Parameter T_PRESS, default 4: cycles each button is held during replay.
REQ-003 Parameter T_SOLTA, default 4: cycles all buttons are released between replayed presses.
REQ-004 Parameter T_QUIETO, default 16: consecutive cycles of leds==0 that end an observation.
REQ-005 clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 habilita  input  1  player enable; low forces IDLE.
REQ-008 leds  input  7  LED pattern driven by the game; each step is one-hot.
REQ-009 botoes  output  7  registered button pattern presented to the game.
REQ-010 jogando  output  1  high while in PRESSIONA or SOLTA.
REQ-011 overflow  output  1  sticky; set when a pattern arrives with the buffer full.
REQ-012 padrao_invalido  output  1  sticky; set when a non-zero, non-one-hot pattern is seen.
REQ-013 db_contagem  output  4  number of stored entries minus 1; 0 when empty.
REQ-014 db_estado  output  2  state code: IDLE=0, OBSERVA=1, PRESSIONA=2, SOLTA=3.

Function
REQ-015 FSM transitions: IDLE->OBSERVA when habilita=1.
REQ-016 FSM transitions: OBSERVA->PRESSIONA on quiet timeout with count>0.
REQ-017 FSM transitions: PRESSIONA->SOLTA after T_PRESS cycles.
REQ-018 FSM transitions: SOLTA->PRESSIONA (next entry) after T_SOLTA cycles while entries remain.
REQ-019 FSM transitions: SOLTA->OBSERVA after the last entry's T_SOLTA cycles.
REQ-020 Entering OBSERVA clears count, the quiet counter and the previous-leds register; buffer contents are don't-care.
REQ-021 Capture rule: in OBSERVA, a one-hot leds value with previous-cycle leds==0 writes one entry at address count and increments count; capture latency is 1 cycle.
REQ-022 A pattern held for multiple cycles is captured once.
REQ-023 Two patterns without an intervening zero cycle: the second is not captured.
REQ-024 Non-zero, non-one-hot leds at a rising edge: no write; set padrao_invalido.
REQ-025 One-hot rising edge with count==PROF: no write; set overflow; count saturates at PROF.
REQ-026 Quiet counter increments each OBSERVA cycle with leds==0 and resets to 0 on any non-zero leds.
REQ-027 Timeout fires when the quiet counter reaches T_QUIETO-1 with leds==0 in that cycle.
REQ-028 Timeout with count==0 keeps the FSM in OBSERVA and restarts the quiet counter.
REQ-029 Replay order: entries 0..count-1, in capture order.
REQ-030 botoes equals the entry for exactly T_PRESS cycles in PRESSIONA, then 0 for exactly T_SOLTA cycles in SOLTA.
REQ-031 The first replay press appears the cycle after timeout fires.
REQ-032 leds is ignored in PRESSIONA and SOLTA.
REQ-033 habilita=0 in any state: next cycle IDLE, botoes=0, sticky flags retained.
REQ-034 habilita=0 has priority over every other transition.
REQ-035 botoes is never non-zero outside PRESSIONA.

Reset
REQ-036 reset=1 at a clock edge sets state IDLE, botoes=0, jogando=0, overflow=0, padrao_invalido=0, count=0 and all timers to 0.
REQ-037 Reset has priority over habilita and applies mid-replay, leaving no partial press.
REQ-038 Buffer RAM contents are not reset.

Structure
REQ-039 A shared package holds the state encoding constants and default parameter values; the codebase's db_estado display logic reuses the same encoding.
REQ-040 Sub-module memoria_sequencia: PROF x 7 synchronous-write, combinational-read register file with we, endereco[3:0], dado_in[6:0] and dado_out[6:0].
REQ-041 The FSM, timers and counters reside in jogador_automatico.

Verification
REQ-042 leds sequence 0x01, 0x00, 0x08, 0x00, 0x40, then 16 zero cycles -> botoes replays 0x01, 0x08, 0x40, each held 4 cycles with 4 zero cycles between; jogando is high throughout replay; the FSM then returns to OBSERVA.
REQ-043 leds=0x04 held 10 cycles, then quiet -> exactly one replay press of 0x04 and db_contagem=0.
REQ-044 leds=0x05 -> padrao_invalido=1 and nothing stored; a following 0x02 replays alone.
REQ-045 17 distinct one-hot pulses -> overflow=1 and 16 presses replayed.
REQ-046 habilita dropped during the 2nd press -> botoes=0 the next cycle and state IDLE.
REQ-047 reset mid-replay -> all outputs 0, then re-enabling starts a fresh observation.
